serial_shifter: RTL



---
 rtl/serial_shifter.sv | 76 +++++++
 1 files changed

// File: rtl/serial_shifter.sv
// serial_shifter: multi-cycle ASR/LSR/LSL shifter moving STEP bit positions per cycle
// over valid/ready request and response channels.
module serial_shifter #(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        aluc1,
  input  logic        aluc0,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Result,
  output logic        Zero,
  output logic        Carry,
  output logic        Negative,
  output logic        Overflow
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic right, arith, cout;
  logic [4:0] rem, k;
  logic [31:0] nxt;
  logic signed [31:0] sra;
  if (STEP != 1 && STEP != 2 && STEP != 4 && STEP != 8 && STEP != 16) begin : g_bad_step
    $error("serial_shifter: STEP must be 1, 2, 4, 8 or 16");
  end
  // Result doubles as the working register while shifting.
  always_comb begin
    k = (rem < 5'(STEP)) ? rem : 5'(STEP);
    sra = $signed(Result) >>> k;
    nxt = !right ? Result << k : arith ? sra : Result >> k;
    cout = right ? Result[k - 5'd1] : Result[5'd0 - k];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      Result <= '0;
      rem <= '0;
      right <= 1'b0;
      arith <= 1'b0;
      Carry <= 1'b0;
      Zero <= 1'b0;
      Negative <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          Result <= B;
          right <= !aluc1;
          arith <= !aluc1 && !aluc0;
          rem <= A[4:0];
          Carry <= 1'b0;
          Zero <= B == '0;
          Negative <= B[31];
          state <= A[4:0] == '0 ? DONE : SHIFT;
        end
        SHIFT: begin
          Result <= nxt;
          rem <= rem - k;
          Carry <= cout;
          Zero <= nxt == '0;
          Negative <= nxt[31];
          if (rem == k) state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign Overflow = 1'b0;
endmodule
